// File: rtl/uart_loopback_tester_if.sv
// UART-side signal bundle for the loopback tester.
// The tester drives the transmit request/data and watches the tx/rx completion ticks.
interface uart_loopback_tester_if;
    logic       tx_start;
    logic [7:0] w_data;
    logic       tx_done_tick;
    logic       rx_done_tick;
    logic [7:0] r_data;

    modport master (
        output tx_start,
        output w_data,
        input  tx_done_tick,
        input  rx_done_tick,
        input  r_data
    );

    modport slave (
        input  tx_start,
        input  w_data,
        output tx_done_tick,
        output rx_done_tick,
        output r_data
    );
endinterface

// File: rtl/uart_loopback_tester.sv
// Host-side initiator for the UART echo checker.
// Sends an incrementing byte sequence, expects each echo to be the sent byte plus one,
// and keeps saturating pass / error / timeout counters for the run.
module uart_loopback_tester #(
    parameter int         NUM_BYTES      = 256,
    parameter logic [7:0] START_VALUE    = 8'h00,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         GAP_CYCLES     = 16,
    parameter int         CNT_W          = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    uart_loopback_tester_if.master    uart,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [CNT_W-1:0]          pass_count_o,
    output logic [CNT_W-1:0]          err_count_o,
    output logic [CNT_W-1:0]          timeout_count_o,
    output logic [7:0]                last_err_data_o
);

    // One timer serves both the per-byte timeout and the inter-byte gap,
    // so it must be wide enough for whichever limit is larger.
    localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [15:0]   NUM_LAST     = 16'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_RX,
        GAP,
        DONE
    } state_t;

    state_t            state_q,   state_d;
    logic [7:0]        pattern_q, pattern_d;
    logic [15:0]       sentCnt_q, sentCnt_d;
    logic [TW-1:0]     timer_q,   timer_d;
    logic [CNT_W-1:0]  passCnt_q, passCnt_d;
    logic [CNT_W-1:0]  errCnt_q,  errCnt_d;
    logic [CNT_W-1:0]  toCnt_q,   toCnt_d;
    logic [7:0]        lastErr_q, lastErr_d;
    logic              done_q,    done_d;
    logic              busy_q,    busy_d;
    logic              txStart_q, txStart_d;
    logic [7:0]        wData_q,   wData_d;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next-state and next-output logic; every output is computed from the next state
    // so that the registered outputs line up with the state they belong to.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        sentCnt_d = sentCnt_q;
        timer_d   = timer_q;
        passCnt_d = passCnt_q;
        errCnt_d  = errCnt_q;
        toCnt_d   = toCnt_q;
        lastErr_d = lastErr_q;
        done_d    = done_q;
        wData_d   = wData_q;
        txStart_d = 1'b0;
        busy_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    passCnt_d = '0;
                    errCnt_d  = '0;
                    toCnt_d   = '0;
                    done_d    = 1'b0;
                    pattern_d = START_VALUE;
                    sentCnt_d = '0;
                    timer_d   = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                timer_d = '0;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (uart.tx_done_tick) begin
                    timer_d = '0;
                    state_d = WAIT_RX;
                end else if (timer_q == TIMEOUT_LAST) begin
                    toCnt_d = satInc(toCnt_q);
                    timer_d = '0;
                    state_d = GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_RX: begin
                // A tick on the final timeout cycle still counts as an echo.
                if (uart.rx_done_tick) begin
                    if (uart.r_data == 8'(pattern_q + 8'd1)) begin
                        passCnt_d = satInc(passCnt_q);
                    end else begin
                        errCnt_d  = satInc(errCnt_q);
                        lastErr_d = uart.r_data;
                    end
                    timer_d = '0;
                    state_d = GAP;
                end else if (timer_q == TIMEOUT_LAST) begin
                    toCnt_d = satInc(toCnt_q);
                    timer_d = '0;
                    state_d = GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d   = '0;
                    sentCnt_d = sentCnt_q + 16'd1;
                    if (sentCnt_q == NUM_LAST) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        pattern_d = pattern_q + 8'd1;
                        state_d   = SEND;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        txStart_d = (state_d == SEND);
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        if (state_d == SEND) begin
            wData_d = pattern_d;
        end
    end

    // State and output registers; reset abandons any run in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pattern_q <= START_VALUE;
            sentCnt_q <= '0;
            timer_q   <= '0;
            passCnt_q <= '0;
            errCnt_q  <= '0;
            toCnt_q   <= '0;
            lastErr_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            txStart_q <= 1'b0;
            wData_q   <= START_VALUE;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            sentCnt_q <= sentCnt_d;
            timer_q   <= timer_d;
            passCnt_q <= passCnt_d;
            errCnt_q  <= errCnt_d;
            toCnt_q   <= toCnt_d;
            lastErr_q <= lastErr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            txStart_q <= txStart_d;
            wData_q   <= wData_d;
        end
    end

    assign uart.tx_start   = txStart_q;
    assign uart.w_data     = wData_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_count_o    = passCnt_q;
    assign err_count_o     = errCnt_q;
    assign timeout_count_o = toCnt_q;
    assign last_err_data_o = lastErr_q;

endmodule
